// File: rtl/axi4mm_lite_csr_bank_pkg.sv
// ---------------------------------------------------------------------------
// axi4mm_lite_csr_bank_pkg
//
// Shared AXI4-Lite types and helpers for the CSR bank:
//   axi_resp_t / axi_prot_t  : response and protection field types
//   OKAY / SLVERR            : response encodings used by the bank
//   csr_wstate_t             : write-path FSM states (W_IDLE, W_RESP)
//   csr_rstate_t             : read-path FSM states (R_IDLE, R_DATA)
//   strb_merge()             : byte-strobe merge of a new word over an old one
// ---------------------------------------------------------------------------
package axi4mm_lite_csr_bank_pkg;

   typedef logic [1:0] axi_resp_t;
   typedef logic [2:0] axi_prot_t;

   localparam axi_resp_t OKAY   = 2'b00;
   localparam axi_resp_t SLVERR = 2'b10;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } csr_wstate_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } csr_rstate_t;

   // Works on the widest supported word (64 bits / 8 strobes); callers
   // zero-extend narrower words and truncate the result back.
   function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                              input logic [63:0] new_word,
                                              input logic [7:0]  strb);
      logic [63:0] merged;
      merged = old_word;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi4mm_lite_csr_bank_if.sv
// ---------------------------------------------------------------------------
// axi4mm_lite_csr_bank_if
//
// AXI4-Lite bus bundle between a manager and the CSR bank.
//   Parameters : ADDR_WIDTH (byte address width), DATA_WIDTH (32 or 64)
//   Channels   : AW (s_awaddr/s_awprot/s_awvalid/s_awready)
//                W  (s_wdata/s_wstrb/s_wvalid/s_wready)
//                B  (s_bresp/s_bvalid/s_bready)
//                AR (s_araddr/s_arprot/s_arvalid/s_arready)
//                R  (s_rdata/s_rresp/s_rvalid/s_rready)
//   Modports   : master (drives requests), slave (drives readies/responses)
//
// Handshake: a beat transfers on a rising clk edge where both valid and
// ready are high. Once valid is raised the sender holds it and the payload
// stable until that edge; ready may change freely and never waits on a
// later valid of the same channel.
// ---------------------------------------------------------------------------
interface axi4mm_lite_csr_bank_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) ();
   import axi4mm_lite_csr_bank_pkg::*;

   logic [ADDR_WIDTH-1:0]   s_awaddr;
   axi_prot_t               s_awprot;
   logic                    s_awvalid;
   logic                    s_awready;

   logic [DATA_WIDTH-1:0]   s_wdata;
   logic [DATA_WIDTH/8-1:0] s_wstrb;
   logic                    s_wvalid;
   logic                    s_wready;

   axi_resp_t               s_bresp;
   logic                    s_bvalid;
   logic                    s_bready;

   logic [ADDR_WIDTH-1:0]   s_araddr;
   axi_prot_t               s_arprot;
   logic                    s_arvalid;
   logic                    s_arready;

   logic [DATA_WIDTH-1:0]   s_rdata;
   axi_resp_t               s_rresp;
   logic                    s_rvalid;
   logic                    s_rready;

   modport master (
      output s_awaddr, s_awprot, s_awvalid, input  s_awready,
      output s_wdata,  s_wstrb,  s_wvalid,  input  s_wready,
      input  s_bresp,  s_bvalid, output s_bready,
      output s_araddr, s_arprot, s_arvalid, input  s_arready,
      input  s_rdata,  s_rresp,  s_rvalid,  output s_rready
   );

   modport slave (
      input  s_awaddr, s_awprot, s_awvalid, output s_awready,
      input  s_wdata,  s_wstrb,  s_wvalid,  output s_wready,
      output s_bresp,  s_bvalid, input  s_bready,
      input  s_araddr, s_arprot, s_arvalid, output s_arready,
      output s_rdata,  s_rresp,  s_rvalid,  input  s_rready
   );

endinterface

// File: rtl/axi4mm_lite_csr_wr_capture.sv
// ---------------------------------------------------------------------------
// axi4mm_lite_csr_wr_capture
//
// Independent AW / W hold registers that join into one write request.
//   clk, reset          : clock, async active-high reset
//   accept_en           : write path may take new beats (bank idle, out of reset)
//   clear               : request consumed this edge; drop both holds
//   awaddr/awvalid/awready : AW channel
//   wdata/wstrb/wvalid/wready : W channel
//   join_valid          : both halves held (registered)
//   join_addr/data/strb : held request payload
// ---------------------------------------------------------------------------
module axi4mm_lite_csr_wr_capture #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    accept_en,
   input  logic                    clear,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic                    join_valid,
   output logic [ADDR_WIDTH-1:0]   join_addr,
   output logic [DATA_WIDTH-1:0]   join_data,
   output logic [DATA_WIDTH/8-1:0] join_strb
);

   logic                    aw_held_q, aw_held_d;
   logic                    w_held_q,  w_held_d;
   logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
   logic [DATA_WIDTH-1:0]   data_q,    data_d;
   logic [DATA_WIDTH/8-1:0] strb_q,    strb_d;

   logic aw_fire;
   logic w_fire;

   // Each channel stalls only on its own hold slot.
   assign awready = accept_en && !aw_held_q;
   assign wready  = accept_en && !w_held_q;
   assign aw_fire = awready && awvalid;
   assign w_fire  = wready && wvalid;

   always_comb begin
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      addr_d    = addr_q;
      data_d    = data_q;
      strb_d    = strb_q;
      if (clear) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end
      if (aw_fire) begin
         aw_held_d = 1'b1;
         addr_d    = awaddr;
      end
      if (w_fire) begin
         w_held_d = 1'b1;
         data_d   = wdata;
         strb_d   = wstrb;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
      end
   end

   assign join_valid = aw_held_q && w_held_q;
   assign join_addr  = addr_q;
   assign join_data  = data_q;
   assign join_strb  = strb_q;

endmodule

// File: rtl/axi4mm_lite_csr_bank.sv
// ---------------------------------------------------------------------------
// axi4mm_lite_csr_bank
//
// AXI4-Lite subordinate register bank of NUM_REGS words. Control registers
// are software-written and drive hw_ctrl; registers flagged in RO_MASK are
// read-only and return the matching hw_status slice.
//
// Ports:
//   clk, reset   : single clock, async active-high reset (sync release)
//   s            : AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   hw_ctrl      : control register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//                  (read-only slots drive 0)
//   hw_status    : status inputs, only RO_MASK slots are used
//   hw_wpulse    : one-cycle pulse per register after an OKAY write
//                  (present only when PIRADIP_AXIL_CSR_WPULSE_EN is defined)
//   dbg_wstate   : write FSM state
//   dbg_rstate   : read FSM state
//
// Optional feature macro: PIRADIP_AXIL_CSR_WPULSE_EN
// ---------------------------------------------------------------------------
module axi4mm_lite_csr_bank
   import axi4mm_lite_csr_bank_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                             clk,
   input  logic                             reset,
   axi4mm_lite_csr_bank_if.slave            s,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   hw_ctrl,
   input  logic [NUM_REGS*DATA_WIDTH-1:0]   hw_status,
`ifdef PIRADIP_AXIL_CSR_WPULSE_EN
   output logic [NUM_REGS-1:0]              hw_wpulse,
`endif
   output csr_wstate_t                      dbg_wstate,
   output csr_rstate_t                      dbg_rstate
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int BYTE_OFF = $clog2(STRB_W);
   localparam int IDX_W    = ADDR_WIDTH - BYTE_OFF;

   csr_wstate_t wstate_q, wstate_d;
   csr_rstate_t rstate_q, rstate_d;

   // Low until the first edge after reset release, so all readies start at 0.
   logic live_q, live_d;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] ctrl_q, ctrl_d;
   axi_resp_t                           bresp_q, bresp_d;
   axi_resp_t                           rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;

   logic                  join_valid;
   logic [ADDR_WIDTH-1:0] join_addr;
   logic [DATA_WIDTH-1:0] join_data;
   logic [STRB_W-1:0]     join_strb;

   logic                  wr_accept_en;
   logic                  commit;
   logic                  bvalid;
   logic                  arready;
   logic                  rvalid;
   logic                  ar_fire;

   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic [NUM_REGS-1:0]   wr_hit;
   logic [NUM_REGS-1:0]   rd_hit;
   logic                  wr_okay;

   // ---------------------------------------------------------------------
   // AW / W capture and join
   // ---------------------------------------------------------------------
   axi4mm_lite_csr_wr_capture #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_wr_capture (
      .clk        (clk),
      .reset      (reset),
      .accept_en  (wr_accept_en),
      .clear      (commit),
      .awaddr     (s.s_awaddr),
      .awvalid    (s.s_awvalid),
      .awready    (s.s_awready),
      .wdata      (s.s_wdata),
      .wstrb      (s.s_wstrb),
      .wvalid     (s.s_wvalid),
      .wready     (s.s_wready),
      .join_valid (join_valid),
      .join_addr  (join_addr),
      .join_data  (join_data),
      .join_strb  (join_strb)
   );

   // ---------------------------------------------------------------------
   // Address decode: one-hot hit vectors; an out-of-range index hits nothing
   // ---------------------------------------------------------------------
   assign wr_idx = join_addr[ADDR_WIDTH-1:BYTE_OFF];
   assign rd_idx = s.s_araddr[ADDR_WIDTH-1:BYTE_OFF];

   always_comb begin
      wr_hit = '0;
      rd_hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_hit[i] = (32'(wr_idx) == i);
         rd_hit[i] = (32'(rd_idx) == i);
      end
   end

   assign wr_okay = |(wr_hit & ~RO_MASK);

   // ---------------------------------------------------------------------
   // Write FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) wstate_q <= W_IDLE;
      else       wstate_q <= wstate_d;
   end

   always_comb begin
      wstate_d = wstate_q;
      case (wstate_q)
         W_IDLE:  if (join_valid) wstate_d = W_RESP;
         W_RESP:  if (s.s_bready) wstate_d = W_IDLE;
         default: wstate_d = W_IDLE;
      endcase
   end

   always_comb begin
      wr_accept_en = 1'b0;
      commit       = 1'b0;
      bvalid       = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            wr_accept_en = live_q;
            commit       = join_valid;
         end
         W_RESP:  bvalid = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Read FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rstate_q <= R_IDLE;
      else       rstate_q <= rstate_d;
   end

   always_comb begin
      rstate_d = rstate_q;
      case (rstate_q)
         R_IDLE:  if (ar_fire) rstate_d = R_DATA;
         R_DATA:  if (s.s_rready) rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      arready = 1'b0;
      rvalid  = 1'b0;
      case (rstate_q)
         R_IDLE:  arready = live_q;
         R_DATA:  rvalid  = 1'b1;
         default: ;
      endcase
   end

   assign ar_fire = arready && s.s_arvalid;

   // ---------------------------------------------------------------------
   // Register file, responses and read data
   // ---------------------------------------------------------------------
   always_comb begin
      live_d  = 1'b1;
      ctrl_d  = ctrl_q;
      bresp_d = bresp_q;
      if (commit) begin
         bresp_d = wr_okay ? OKAY : SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit[i] && !RO_MASK[i]) begin
               ctrl_d[i] = DATA_WIDTH'(strb_merge(64'(ctrl_q[i]), 64'(join_data),
                                                  8'(join_strb)));
            end
         end
      end
   end

   // The read samples ctrl_q, so a write committing at the same edge is
   // not yet visible: the read returns the pre-write value.
   always_comb begin
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      if (ar_fire) begin
         rdata_d = '0;
         rresp_d = (|rd_hit) ? OKAY : SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_hit[i]) begin
               rdata_d = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : ctrl_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live_q  <= 1'b0;
         ctrl_q  <= {NUM_REGS{RESET_VAL}};
         bresp_q <= OKAY;
         rresp_q <= OKAY;
         rdata_q <= '0;
      end else begin
         live_q  <= live_d;
         ctrl_q  <= ctrl_d;
         bresp_q <= bresp_d;
         rresp_q <= rresp_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef PIRADIP_AXIL_CSR_WPULSE_EN
   logic [NUM_REGS-1:0] wpulse_q, wpulse_d;

   // Fires on every OKAY commit, including an all-zero strobe.
   always_comb begin
      wpulse_d = '0;
      if (commit) wpulse_d = wr_hit & ~RO_MASK;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) wpulse_q <= '0;
      else       wpulse_q <= wpulse_d;
   end

   assign hw_wpulse = wpulse_q;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   always_comb begin
      hw_ctrl = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         hw_ctrl[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : ctrl_q[i];
      end
   end

   assign s.s_bvalid  = bvalid;
   assign s.s_bresp   = bresp_q;
   assign s.s_arready = arready;
   assign s.s_rvalid  = rvalid;
   assign s.s_rresp   = rresp_q;
   assign s.s_rdata   = rdata_q;

   assign dbg_wstate = wstate_q;
   assign dbg_rstate = rstate_q;

   // Protection bits, byte-offset bits and non-status hw_status slots
   // carry no meaning for this bank.
   logic unused_bits;
   assign unused_bits = ^{s.s_awprot, s.s_arprot, s.s_araddr[BYTE_OFF-1:0],
                          join_addr[BYTE_OFF-1:0], hw_status};

endmodule

// File: tb/tb_axi4mm_lite_csr_bank.sv
module tb_axi4mm_lite_csr_bank;
  import axi4mm_lite_csr_bank_pkg::*;

  localparam int             AW     = 8;
  localparam int             DW     = 32;
  localparam int             NR     = 16;
  localparam logic [NR-1:0]  RO     = 16'h0008;
  localparam logic [DW-1:0]  RV     = 32'h1111_2222;
  localparam int             BUDGET = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi4mm_lite_csr_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [NR*DW-1:0] hw_ctrl;
  logic [NR*DW-1:0] hw_status;
  csr_wstate_t      dbg_wstate;
  csr_rstate_t      dbg_rstate;
`ifdef PIRADIP_AXIL_CSR_WPULSE_EN
  logic [NR-1:0]    hw_wpulse;
`endif

  axi4mm_lite_csr_bank #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (RO),
    .RESET_VAL  (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (bus),
    .hw_ctrl    (hw_ctrl),
    .hw_status  (hw_status),
`ifdef PIRADIP_AXIL_CSR_WPULSE_EN
    .hw_wpulse  (hw_wpulse),
`endif
    .dbg_wstate (dbg_wstate),
    .dbg_rstate (dbg_rstate)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model[NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_hw_ctrl(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s hw_ctrl[%0d]", tag, i), hw_ctrl[i*DW +: DW], RO[i] ? 32'h0 : model[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_b(output logic [1:0] resp, output int b_wait, output bit ok);
    ok = 1'b0;
    resp = 2'bxx;
    b_wait = -1;
    bus.s_bready = 1'b1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (bus.s_bvalid) begin
        resp = bus.s_bresp;
        b_wait = k;
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    bus.s_bready = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int b_wait, output bit ok);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit aw_fire, w_fire;
    int cyc = 0;
    ok = 1'b0;
    resp = 2'bxx;
    b_wait = -1;
    while (!(aw_done && w_done) && cyc < BUDGET) begin
      if (!aw_done && cyc >= aw_dly) begin
        bus.s_awvalid = 1'b1;
        bus.s_awaddr = addr;
      end
      if (!w_done && cyc >= w_dly) begin
        bus.s_wvalid = 1'b1;
        bus.s_wdata = data;
        bus.s_wstrb = strb;
      end
      @(negedge clk);
      aw_fire = bus.s_awvalid && bus.s_awready;
      w_fire = bus.s_wvalid && bus.s_wready;
      @(posedge clk); #1;
      if (aw_fire) begin aw_done = 1'b1; bus.s_awvalid = 1'b0; end
      if (w_fire) begin w_done = 1'b1; bus.s_wvalid = 1'b0; end
      cyc++;
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0;
    if (aw_done && w_done) wait_b(resp, b_wait, ok);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp, output int r_wait, output bit ok);
    bit ar_done = 1'b0;
    ok = 1'b0;
    data = 'x;
    resp = 2'bxx;
    r_wait = -1;
    bus.s_araddr = addr;
    bus.s_arvalid = 1'b1;
    for (int k = 0; k < BUDGET && !ar_done; k++) begin
      @(negedge clk);
      ar_done = bus.s_arready;
      @(posedge clk); #1;
    end
    bus.s_arvalid = 1'b0;
    if (!ar_done) return;
    bus.s_rready = 1'b1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (bus.s_rvalid) begin
        data = bus.s_rdata;
        resp = bus.s_rresp;
        r_wait = k;
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    bus.s_rready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
    int            aw_dly;
    int            w_dly;
    logic [1:0]    exp_bresp;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_rresp;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    int            lat;
    bit            ok;
    int            idx;

    vecs[0] = '{8'h04, 32'hDEADBEEF, 4'hF, 0, 0, OKAY,   32'hDEADBEEF, OKAY};
    vecs[1] = '{8'h08, 32'hAAAAAAAA, 4'hF, 0, 0, OKAY,   32'hAAAAAAAA, OKAY};
    vecs[2] = '{8'h08, 32'h12345678, 4'h3, 3, 0, OKAY,   32'hAAAA5678, OKAY};
    vecs[3] = '{8'h40, 32'hFFFFFFFF, 4'hF, 0, 0, SLVERR, 32'h00000000, SLVERR};
    vecs[4] = '{8'h0C, 32'h01234567, 4'hF, 0, 0, SLVERR, 32'hCAFEF00D, OKAY};
    vecs[5] = '{8'h3D, 32'h87654321, 4'hC, 0, 2, OKAY,   32'h87652222, OKAY};
    vecs[6] = '{8'h06, 32'h00FF00FF, 4'h0, 1, 0, OKAY,   32'hDEADBEEF, OKAY};
    vecs[7] = '{8'h00, 32'hCAFEBABE, 4'hA, 0, 0, OKAY,   32'hCA11BA22, OKAY};
    vecs[8] = '{8'hFC, 32'h55555555, 4'hF, 0, 0, SLVERR, 32'h00000000, SLVERR};

    bus.s_awaddr = '0; bus.s_awprot = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata = '0;  bus.s_wstrb = '0;  bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    bus.s_araddr = '0; bus.s_arprot = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      hw_status[i*DW +: DW] = 32'hBAD0_0000 | 32'(i);
      model[i] = RV;
    end
    hw_status[3*DW +: DW] = 32'hCAFEF00D;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst awready", 32'(bus.s_awready), 0);
    check("rst wready", 32'(bus.s_wready), 0);
    check("rst arready", 32'(bus.s_arready), 0);
    check("rst bvalid", 32'(bus.s_bvalid), 0);
    check("rst rvalid", 32'(bus.s_rvalid), 0);
    check("rst bresp", 32'(bus.s_bresp), 0);
    check("rst rresp", 32'(bus.s_rresp), 0);
    check("rst rdata", bus.s_rdata, 0);
    check("rst wstate", 32'(dbg_wstate), 32'(W_IDLE));
    check_hw_ctrl("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("release awready before edge", 32'(bus.s_awready), 0);
    check("release arready before edge", 32'(bus.s_arready), 0);
    @(posedge clk); #1;
    check("release awready", 32'(bus.s_awready), 1);
    check("release wready", 32'(bus.s_wready), 1);
    check("release arready", 32'(bus.s_arready), 1);

    // Untouched register reads back the reset value.
    axi_read(8'h14, rdata, resp, lat, ok);
    check("reg5 read ok", 32'(ok), 1);
    check("reg5 reset rdata", rdata, RV);
    check("reg5 reset rresp", 32'(resp), 32'(OKAY));

    // ---- table-driven vectors ----
    for (int v = 0; v < 9; v++) begin
      axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].aw_dly, vecs[v].w_dly,
                resp, lat, ok);
      check($sformatf("v%0d write done", v), 32'(ok), 1);
      check($sformatf("v%0d bresp", v), 32'(resp), 32'(vecs[v].exp_bresp));
      check($sformatf("v%0d b latency", v), lat, 1);
      @(negedge clk);
      check($sformatf("v%0d single bvalid", v), 32'(bus.s_bvalid), 0);
      @(posedge clk); #1;

      exp_q.push_back(vecs[v].exp_rdata);
      axi_read(vecs[v].addr, rdata, resp, lat, ok);
      check($sformatf("v%0d read done", v), 32'(ok), 1);
      check($sformatf("v%0d rdata", v), rdata, exp_q.pop_front());
      check($sformatf("v%0d rresp", v), 32'(resp), 32'(vecs[v].exp_rresp));
      check($sformatf("v%0d r latency", v), lat, 0);

      idx = 32'(vecs[v].addr[AW-1:2]);
      if (idx < NR && !RO[idx] && vecs[v].exp_bresp == OKAY) model[idx] = vecs[v].exp_rdata;
      check_hw_ctrl($sformatf("v%0d", v));
    end

    // ---- B back-pressure: response held, second write not taken ----
    bus.s_awaddr = 8'h18; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h0F0F0F0F; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(negedge clk);
    check("stall aw ready", 32'(bus.s_awready), 1);
    check("stall w ready", 32'(bus.s_wready), 1);
    @(posedge clk); #1;
    bus.s_awaddr = 8'h1C; bus.s_wdata = 32'h77777777;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bstall%0d bvalid", k), 32'(bus.s_bvalid), 1);
      check($sformatf("bstall%0d bresp", k), 32'(bus.s_bresp), 32'(OKAY));
      check($sformatf("bstall%0d awready", k), 32'(bus.s_awready), 0);
      check($sformatf("bstall%0d wready", k), 32'(bus.s_wready), 0);
      check($sformatf("bstall%0d wstate", k), 32'(dbg_wstate), 32'(W_RESP));
    end
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b1;
    @(negedge clk);
    check("bstall release bvalid", 32'(bus.s_bvalid), 1);
    @(posedge clk); #1;
    bus.s_bready = 1'b0;
    @(negedge clk);
    check("bstall after bvalid", 32'(bus.s_bvalid), 0);
    check("bstall no held aw", 32'(bus.s_awready), 1);
    check("bstall no held w", 32'(bus.s_wready), 1);
    model[6] = 32'h0F0F0F0F;
    check_hw_ctrl("bstall");
    @(posedge clk); #1;

    // ---- R back-pressure: data frozen, second read not taken ----
    bus.s_araddr = 8'h18; bus.s_arvalid = 1'b1;
    @(negedge clk);
    check("rstall arready", 32'(bus.s_arready), 1);
    @(posedge clk); #1;
    bus.s_araddr = 8'h04;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rstall%0d rvalid", k), 32'(bus.s_rvalid), 1);
      check($sformatf("rstall%0d rdata", k), bus.s_rdata, 32'h0F0F0F0F);
      check($sformatf("rstall%0d arready", k), 32'(bus.s_arready), 0);
    end
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b1;
    @(negedge clk);
    check("rstall release rdata", bus.s_rdata, 32'h0F0F0F0F);
    @(posedge clk); #1;
    bus.s_rready = 1'b0;
    @(negedge clk);
    check("rstall after rvalid", 32'(bus.s_rvalid), 0);
    check("rstall arready back", 32'(bus.s_arready), 1);
    @(posedge clk); #1;

    // ---- read/write collision on reg9: read sees pre-write value ----
    bus.s_awaddr = 8'h24; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h99999999; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    bus.s_araddr = 8'h24; bus.s_arvalid = 1'b1; bus.s_bready = 1'b1;
    @(negedge clk);
    check("coll arready", 32'(bus.s_arready), 1);
    check("coll bvalid before commit", 32'(bus.s_bvalid), 0);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
    @(negedge clk);
    check("coll rvalid", 32'(bus.s_rvalid), 1);
    check("coll pre-write rdata", bus.s_rdata, RV);
    check("coll bvalid", 32'(bus.s_bvalid), 1);
    @(posedge clk); #1;
    bus.s_rready = 1'b0; bus.s_bready = 1'b0;
    model[9] = 32'h99999999;
    axi_read(8'h24, rdata, resp, lat, ok);
    check("coll post-write rdata", rdata, 32'h99999999);

    // ---- reset mid-transaction: held W and pending R are dropped ----
    bus.s_wdata = 32'h5555AAAA; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(negedge clk);
    check("mid w accepted", 32'(bus.s_wready), 1);
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0;
    bus.s_araddr = 8'h04; bus.s_arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    @(negedge clk);
    check("mid rvalid pending", 32'(bus.s_rvalid), 1);
    check("mid wready while held", 32'(bus.s_wready), 0);
    #2 reset = 1'b1;
    #1;
    check("mid rst rvalid", 32'(bus.s_rvalid), 0);
    check("mid rst bvalid", 32'(bus.s_bvalid), 0);
    check("mid rst awready", 32'(bus.s_awready), 0);
    check("mid rst wready", 32'(bus.s_wready), 0);
    check("mid rst arready", 32'(bus.s_arready), 0);
    check("mid rst rdata", bus.s_rdata, 0);
    for (int i = 0; i < NR; i++) model[i] = RV;
    check_hw_ctrl("mid rst");
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid release wready before edge", 32'(bus.s_wready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid release awready", 32'(bus.s_awready), 1);
    check("mid release wready", 32'(bus.s_wready), 1);
    check("mid release arready", 32'(bus.s_arready), 1);
    check("mid no stale rvalid", 32'(bus.s_rvalid), 0);
    @(posedge clk); #1;
    // AW alone must not commit: the pre-reset W beat is gone.
    bus.s_awaddr = 8'h04; bus.s_awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mid aw-only bvalid%0d", k), 32'(bus.s_bvalid), 0);
    end
    check("mid aw-only reg1", hw_ctrl[1*DW +: DW], RV);
    @(posedge clk); #1;
    bus.s_wdata = 32'h13579BDF; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0;
    wait_b(resp, lat, ok);
    check("mid join done", 32'(ok), 1);
    check("mid join bresp", 32'(resp), 32'(OKAY));
    model[1] = 32'h13579BDF;
    axi_read(8'h04, rdata, resp, lat, ok);
    check("mid join rdata", rdata, 32'h13579BDF);
    check_hw_ctrl("final");
    check("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
